// File: rtl/pipe_ctrl_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pipe_ctrl_scheduler_pkg
// Brief   : Shared pipeline-register modes, scheduler FSM states, hazard width
// Revision: 1.0
// ============================================================================
`ifndef Hazard_Signal_Width
`define Hazard_Signal_Width 4
`endif

package pipe_ctrl_scheduler_pkg;

   localparam int HZ_SIGNAL_W = `Hazard_Signal_Width;

   localparam logic [1:0] c_mode_normal = 2'b00;
   localparam logic [1:0] c_mode_stall  = 2'b01;
   localparam logic [1:0] c_mode_flush  = 2'b10;

   typedef enum logic [1:0] {
      c_st_run  = 2'd0,
      c_st_hold = 2'd1,
      c_st_memw = 2'd2
   } ctrl_state_t;

   // The reserved encoding 2'b11 must never reach a pipeline register.
   function automatic logic [1:0] sanitize_mode(input logic [1:0] mode);
      return (mode == 2'b11) ? c_mode_flush : mode;
   endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_ctrl_perf_cnt.sv
`default_nettype none
// ============================================================================
// Module  : pipe_ctrl_perf_cnt
// Brief   : Pair of saturating 32-bit event counters (stall cycles, flushes)
// Revision: 1.0
// ============================================================================
module pipe_ctrl_perf_cnt (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_evt,
   input  logic        flush_evt,
   output logic [31:0] stall_cycles,
   output logic [31:0] flush_events
);

   logic [1:0]  w_evt;
   logic [31:0] r_cnt [2];

   assign w_evt = {flush_evt, stall_evt};

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
         always_ff @(posedge clk) begin
            if (rst) begin
               r_cnt[gi] <= '0;
            end else if (w_evt[gi] && (r_cnt[gi] != 32'hFFFF_FFFF)) begin
               r_cnt[gi] <= r_cnt[gi] + 32'd1;
            end
         end
      end
   endgenerate

   assign stall_cycles = r_cnt[0];
   assign flush_events = r_cnt[1];

endmodule

`default_nettype wire

// File: rtl/pipe_ctrl_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : pipe_ctrl_scheduler
// Brief   : Merges memory-wait, redirect and hazard requests into per-stage
//           pipeline modes; optional perf counters under PIPE_CTRL_PERF_EN.
// Revision: 1.0
// ============================================================================
`ifndef Hazard_Signal_Width
`define Hazard_Signal_Width 4
`endif

module pipe_ctrl_scheduler
   import pipe_ctrl_scheduler_pkg::*;
#(
   parameter int HZ_W = `Hazard_Signal_Width,
   parameter int PC_W = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [1:0]      hz_if_id_mode,
   input  logic [1:0]      hz_id_exe_mode,
   input  logic            hz_if_stall,
   input  logic [HZ_W-1:0] hz_signal_cycle,
   input  logic            mem_busy,
   input  logic            exe_redirect,
   input  logic [PC_W-1:0] exe_redirect_pc,
   output logic            if_stall,
   output logic            if_redirect,
   output logic [PC_W-1:0] if_redirect_pc,
   output logic [1:0]      if_id_mode,
   output logic [1:0]      id_exe_mode,
   output logic [1:0]      exe_mem_mode,
   output logic [1:0]      mem_wb_mode,
   output logic            ctrl_busy
`ifdef PIPE_CTRL_PERF_EN
   ,
   output logic [31:0]     perf_stall_cycles,
   output logic [31:0]     perf_flush_events
`endif
);

   ctrl_state_t     r_state;
   logic [HZ_W-1:0] r_hold_cnt;
   logic [1:0]      r_hold_if_id;
   logic [1:0]      r_hold_id_exe;
   logic            r_hold_if_stall;
   logic            r_pend_valid;
   logic [PC_W-1:0] r_pend_pc;

   logic            w_pend_fire;
   logic            w_redirect;
   logic [PC_W-1:0] w_redirect_pc;
   logic            w_hz_pass;
   logic            w_replay;

   // A pending redirect leaves MEMW ahead of any fresh EXE redirect.
   assign w_pend_fire   = (r_state == c_st_memw) && r_pend_valid;
   assign w_redirect    = !mem_busy && (w_pend_fire || exe_redirect);
   assign w_redirect_pc = w_pend_fire ? r_pend_pc : exe_redirect_pc;
   assign w_hz_pass     = (r_state == c_st_run) && !mem_busy && !exe_redirect &&
                          (hz_signal_cycle != '0);
   assign w_replay      = (r_state == c_st_hold) && !mem_busy && !exe_redirect;

   always_comb begin
      if_stall       = 1'b0;
      if_redirect    = 1'b0;
      if_redirect_pc = '0;
      if_id_mode     = c_mode_normal;
      id_exe_mode    = c_mode_normal;
      exe_mem_mode   = c_mode_normal;
      mem_wb_mode    = c_mode_normal;
      ctrl_busy      = 1'b0;
      if (rst) begin
         if_stall     = 1'b1;
         if_id_mode   = c_mode_flush;
         id_exe_mode  = c_mode_flush;
         exe_mem_mode = c_mode_flush;
         mem_wb_mode  = c_mode_flush;
      end else begin
         ctrl_busy = (r_state != c_st_run);
         if (mem_busy) begin
            if_stall     = 1'b1;
            if_id_mode   = c_mode_stall;
            id_exe_mode  = c_mode_stall;
            exe_mem_mode = c_mode_stall;
            mem_wb_mode  = c_mode_flush;
         end else if (w_redirect) begin
            if_redirect    = 1'b1;
            if_redirect_pc = w_redirect_pc;
            if_id_mode     = c_mode_flush;
            id_exe_mode    = c_mode_flush;
         end else if (w_hz_pass) begin
            if_stall    = hz_if_stall;
            if_id_mode  = sanitize_mode(hz_if_id_mode);
            id_exe_mode = sanitize_mode(hz_id_exe_mode);
         end else if (w_replay) begin
            if_stall    = r_hold_if_stall;
            if_id_mode  = r_hold_if_id;
            id_exe_mode = r_hold_id_exe;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state         <= c_st_run;
         r_hold_cnt      <= '0;
         r_hold_if_id    <= c_mode_normal;
         r_hold_id_exe   <= c_mode_normal;
         r_hold_if_stall <= 1'b0;
         r_pend_valid    <= 1'b0;
         r_pend_pc       <= '0;
      end else if (mem_busy) begin
         // Memory wait wins from every state; a redirect seen now is deferred.
         r_state    <= c_st_memw;
         r_hold_cnt <= '0;
         if (exe_redirect) begin
            r_pend_valid <= 1'b1;
            r_pend_pc    <= exe_redirect_pc;
         end
      end else begin
         case (r_state)
            c_st_run: begin
               if (!exe_redirect && (hz_signal_cycle > HZ_W'(1))) begin
                  r_state         <= c_st_hold;
                  r_hold_cnt      <= hz_signal_cycle - HZ_W'(1);
                  r_hold_if_id    <= sanitize_mode(hz_if_id_mode);
                  r_hold_id_exe   <= sanitize_mode(hz_id_exe_mode);
                  r_hold_if_stall <= hz_if_stall;
               end
            end
            c_st_hold: begin
               if (exe_redirect || (r_hold_cnt <= HZ_W'(1))) begin
                  r_state    <= c_st_run;
                  r_hold_cnt <= '0;
               end else begin
                  r_hold_cnt <= r_hold_cnt - HZ_W'(1);
               end
            end
            c_st_memw: begin
               r_state      <= c_st_run;
               r_pend_valid <= 1'b0;
            end
            default: begin
               r_state    <= c_st_run;
               r_hold_cnt <= '0;
            end
         endcase
      end
   end

`ifdef PIPE_CTRL_PERF_EN
   pipe_ctrl_perf_cnt u_perf_cnt (
      .clk          (clk),
      .rst          (rst),
      .stall_evt    (if_stall && !rst),
      .flush_evt    (if_redirect),
      .stall_cycles (perf_stall_cycles),
      .flush_events (perf_flush_events)
   );
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_ctrl_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tb_pipe_ctrl_scheduler
// Brief   : Directed vector table plus randomized run against a reference model
// Revision: 1.0
// ============================================================================
module tb_pipe_ctrl_scheduler;

   localparam int HZ_W = 4;
   localparam int PC_W = 32;
   localparam logic [1:0] N = 2'b00;
   localparam logic [1:0] S = 2'b01;
   localparam logic [1:0] F = 2'b10;

   logic            clk = 1'b0;
   logic            rst;
   logic [1:0]      hz_if_id_mode;
   logic [1:0]      hz_id_exe_mode;
   logic            hz_if_stall;
   logic [HZ_W-1:0] hz_signal_cycle;
   logic            mem_busy;
   logic            exe_redirect;
   logic [PC_W-1:0] exe_redirect_pc;
   logic            if_stall;
   logic            if_redirect;
   logic [PC_W-1:0] if_redirect_pc;
   logic [1:0]      if_id_mode;
   logic [1:0]      id_exe_mode;
   logic [1:0]      exe_mem_mode;
   logic [1:0]      mem_wb_mode;
   logic            ctrl_busy;
`ifdef PIPE_CTRL_PERF_EN
   logic [31:0]     perf_stall_cycles;
   logic [31:0]     perf_flush_events;
`endif

   always #5 clk = ~clk;

   pipe_ctrl_scheduler #(.HZ_W(HZ_W), .PC_W(PC_W)) dut (
      .clk             (clk),
      .rst             (rst),
      .hz_if_id_mode   (hz_if_id_mode),
      .hz_id_exe_mode  (hz_id_exe_mode),
      .hz_if_stall     (hz_if_stall),
      .hz_signal_cycle (hz_signal_cycle),
      .mem_busy        (mem_busy),
      .exe_redirect    (exe_redirect),
      .exe_redirect_pc (exe_redirect_pc),
      .if_stall        (if_stall),
      .if_redirect     (if_redirect),
      .if_redirect_pc  (if_redirect_pc),
      .if_id_mode      (if_id_mode),
      .id_exe_mode     (id_exe_mode),
      .exe_mem_mode    (exe_mem_mode),
      .mem_wb_mode     (mem_wb_mode),
      .ctrl_busy       (ctrl_busy)
`ifdef PIPE_CTRL_PERF_EN
      ,
      .perf_stall_cycles (perf_stall_cycles),
      .perf_flush_events (perf_flush_events)
`endif
   );

   typedef struct {
      logic        rst, mb, er;
      logic [31:0] pc;
      logic [3:0]  hzc;
      logic [1:0]  hzi, hze;
      logic        hzs;
      logic        e_stall, e_red;
      logic [31:0] e_pc;
      logic [1:0]  e_ifid, e_idex, e_exme, e_mewb;
      logic        e_busy;
   } vec_t;

   typedef struct {
      logic        stall, red;
      logic [31:0] pc;
      logic [1:0]  ifid, idex, exme, mewb;
      logic        busy;
   } exp_t;

   int checks   = 0;
   int failures = 0;

   function automatic vec_t mk(
      input logic r, mb, er, input logic [31:0] pc, input logic [3:0] hzc,
      input logic [1:0] hzi, hze, input logic hzs,
      input logic es, ered, input logic [31:0] epc,
      input logic [1:0] e0, e1, e2, e3, input logic eb);
      vec_t v;
      v.rst = r; v.mb = mb; v.er = er; v.pc = pc; v.hzc = hzc;
      v.hzi = hzi; v.hze = hze; v.hzs = hzs;
      v.e_stall = es; v.e_red = ered; v.e_pc = epc;
      v.e_ifid = e0; v.e_idex = e1; v.e_exme = e2; v.e_mewb = e3; v.e_busy = eb;
      return v;
   endfunction

   task automatic drive(input logic r, mb, er, input logic [31:0] pc,
                        input logic [3:0] hzc, input logic [1:0] hzi, hze,
                        input logic hzs);
      rst = r; mem_busy = mb; exe_redirect = er; exe_redirect_pc = pc;
      hz_signal_cycle = hzc; hz_if_id_mode = hzi; hz_id_exe_mode = hze;
      hz_if_stall = hzs;
   endtask

   // The redirect target is only defined while redirecting or in reset.
   task automatic compare(input string name, input int idx, input exp_t e, input logic in_rst);
      logic [42:0] act, expv, mask;
      act  = {if_stall, if_redirect, if_redirect_pc, if_id_mode, id_exe_mode,
              exe_mem_mode, mem_wb_mode, ctrl_busy};
      expv = {e.stall, e.red, e.pc, e.ifid, e.idex, e.exme, e.mewb, e.busy};
      mask = '1;
      if (!(e.red || in_rst)) mask[40:9] = '0;
      checks++;
      if ((act & mask) !== (expv & mask)) begin
         failures++;
         $display("FAIL %s[%0d]: got stall=%b red=%b pc=%h modes=%h/%h/%h/%h busy=%b, expected stall=%b red=%b pc=%h modes=%h/%h/%h/%h busy=%b",
                  name, idx, if_stall, if_redirect, if_redirect_pc, if_id_mode,
                  id_exe_mode, exe_mem_mode, mem_wb_mode, ctrl_busy,
                  e.stall, e.red, e.pc, e.ifid, e.idex, e.exme, e.mewb, e.busy);
      end
   endtask

   // Reference model: wait flag, remaining replay cycles, last deferred redirect.
   bit          m_wait;
   int          m_hold_left;
   logic [1:0]  m_hi, m_he;
   logic        m_hs;
   logic [31:0] m_pend_q[$];

   function automatic exp_t model_out();
      exp_t e;
      e = '{stall:0, red:0, pc:0, ifid:N, idex:N, exme:N, mewb:N, busy:0};
      if (rst) begin
         e = '{stall:1, red:0, pc:0, ifid:F, idex:F, exme:F, mewb:F, busy:0};
         return e;
      end
      e.busy = m_wait || (m_hold_left > 0);
      if (mem_busy) begin
         e.stall = 1; e.ifid = S; e.idex = S; e.exme = S; e.mewb = F;
      end else if (m_wait && m_pend_q.size() > 0) begin
         e.red = 1; e.pc = m_pend_q[0]; e.ifid = F; e.idex = F;
      end else if (exe_redirect) begin
         e.red = 1; e.pc = exe_redirect_pc; e.ifid = F; e.idex = F;
      end else if (m_wait) begin
         // memory wait just ended with nothing pending: all Normal
      end else if (m_hold_left > 0) begin
         e.stall = m_hs; e.ifid = m_hi; e.idex = m_he;
      end else if (hz_signal_cycle != 0) begin
         e.stall = hz_if_stall; e.ifid = hz_if_id_mode; e.idex = hz_id_exe_mode;
      end
      return e;
   endfunction

   task automatic model_step();
      if (rst) begin
         m_wait = 0; m_hold_left = 0; m_pend_q.delete();
      end else if (mem_busy) begin
         m_wait = 1; m_hold_left = 0;
         if (exe_redirect) begin
            m_pend_q.delete();
            m_pend_q.push_back(exe_redirect_pc);
         end
      end else if (m_wait) begin
         m_wait = 0; m_pend_q.delete();
      end else if (exe_redirect) begin
         m_hold_left = 0;
      end else if (m_hold_left > 0) begin
         m_hold_left--;
      end else if (hz_signal_cycle > 1) begin
         m_hold_left = int'(hz_signal_cycle) - 1;
         m_hi = hz_if_id_mode; m_he = hz_id_exe_mode; m_hs = hz_if_stall;
      end
   endtask

   vec_t tbl[$];

   initial begin
      exp_t e;
      logic [1:0] modes [3];
      modes[0] = N; modes[1] = S; modes[2] = F;

      //               rst mb er pc       hzc  hzi hze hzs | stl red epc      ifid idex exme mewb busy
      tbl.push_back(mk(1, 0, 0, 32'h0,   0,   N,  N,  0,   1,  0,  32'h0,   F,   F,   F,   F,   0));
      tbl.push_back(mk(1, 0, 0, 32'h0,   0,   N,  N,  0,   1,  0,  32'h0,   F,   F,   F,   F,   0));
      tbl.push_back(mk(0, 0, 0, 32'h0,   0,   N,  N,  0,   0,  0,  32'h0,   N,   N,   N,   N,   0));
      tbl.push_back(mk(0, 0, 0, 32'h0,   1,   S,  F,  1,   1,  0,  32'h0,   S,   F,   N,   N,   0));
      tbl.push_back(mk(0, 0, 0, 32'h0,   0,   N,  N,  0,   0,  0,  32'h0,   N,   N,   N,   N,   0));
      tbl.push_back(mk(0, 0, 0, 32'h0,   3,   S,  S,  1,   1,  0,  32'h0,   S,   S,   N,   N,   0));
      tbl.push_back(mk(0, 0, 0, 32'h0,   0,   N,  N,  0,   1,  0,  32'h0,   S,   S,   N,   N,   1));
      tbl.push_back(mk(0, 0, 0, 32'h0,   0,   N,  N,  0,   1,  0,  32'h0,   S,   S,   N,   N,   1));
      tbl.push_back(mk(0, 0, 0, 32'h0,   0,   N,  N,  0,   0,  0,  32'h0,   N,   N,   N,   N,   0));
      tbl.push_back(mk(0, 1, 0, 32'h0,   0,   N,  N,  0,   1,  0,  32'h0,   S,   S,   S,   F,   0));
      tbl.push_back(mk(0, 1, 0, 32'h0,   0,   N,  N,  0,   1,  0,  32'h0,   S,   S,   S,   F,   1));
      tbl.push_back(mk(0, 1, 0, 32'h0,   0,   N,  N,  0,   1,  0,  32'h0,   S,   S,   S,   F,   1));
      tbl.push_back(mk(0, 1, 0, 32'h0,   0,   N,  N,  0,   1,  0,  32'h0,   S,   S,   S,   F,   1));
      tbl.push_back(mk(0, 0, 0, 32'h0,   0,   N,  N,  0,   0,  0,  32'h0,   N,   N,   N,   N,   1));
      tbl.push_back(mk(0, 0, 0, 32'h0,   0,   N,  N,  0,   0,  0,  32'h0,   N,   N,   N,   N,   0));
      tbl.push_back(mk(0, 1, 1, 32'h100, 0,   N,  N,  0,   1,  0,  32'h0,   S,   S,   S,   F,   0));
      tbl.push_back(mk(0, 1, 1, 32'h200, 0,   N,  N,  0,   1,  0,  32'h0,   S,   S,   S,   F,   1));
      tbl.push_back(mk(0, 1, 0, 32'h0,   0,   N,  N,  0,   1,  0,  32'h0,   S,   S,   S,   F,   1));
      tbl.push_back(mk(0, 0, 0, 32'h0,   0,   N,  N,  0,   0,  1,  32'h200, F,   F,   N,   N,   1));
      tbl.push_back(mk(0, 0, 0, 32'h0,   0,   N,  N,  0,   0,  0,  32'h0,   N,   N,   N,   N,   0));
      tbl.push_back(mk(0, 0, 1, 32'h40,  1,   S,  S,  1,   0,  1,  32'h40,  F,   F,   N,   N,   0));
      tbl.push_back(mk(0, 0, 0, 32'h0,   0,   N,  N,  0,   0,  0,  32'h0,   N,   N,   N,   N,   0));
      tbl.push_back(mk(0, 0, 0, 32'h0,   4,   S,  F,  1,   1,  0,  32'h0,   S,   F,   N,   N,   0));
      tbl.push_back(mk(0, 0, 0, 32'h0,   0,   N,  N,  0,   1,  0,  32'h0,   S,   F,   N,   N,   1));
      tbl.push_back(mk(0, 0, 1, 32'h80,  0,   N,  N,  0,   0,  1,  32'h80,  F,   F,   N,   N,   1));
      tbl.push_back(mk(0, 0, 0, 32'h0,   0,   N,  N,  0,   0,  0,  32'h0,   N,   N,   N,   N,   0));
      tbl.push_back(mk(0, 1, 0, 32'h0,   0,   N,  N,  0,   1,  0,  32'h0,   S,   S,   S,   F,   0));
      tbl.push_back(mk(1, 0, 0, 32'h0,   0,   N,  N,  0,   1,  0,  32'h0,   F,   F,   F,   F,   0));
      tbl.push_back(mk(0, 0, 0, 32'h0,   0,   N,  N,  0,   0,  0,  32'h0,   N,   N,   N,   N,   0));

      foreach (tbl[i]) begin
         drive(tbl[i].rst, tbl[i].mb, tbl[i].er, tbl[i].pc, tbl[i].hzc,
               tbl[i].hzi, tbl[i].hze, tbl[i].hzs);
         e = '{stall:tbl[i].e_stall, red:tbl[i].e_red, pc:tbl[i].e_pc,
               ifid:tbl[i].e_ifid, idex:tbl[i].e_idex, exme:tbl[i].e_exme,
               mewb:tbl[i].e_mewb, busy:tbl[i].e_busy};
         @(negedge clk);
         compare("vec", i, e, tbl[i].rst);
         @(posedge clk);
         #1;
      end

      m_wait = 0; m_hold_left = 0; m_hi = N; m_he = N; m_hs = 0;
      for (int i = 0; i < 3000; i++) begin
         drive((i < 2) || ($urandom_range(0, 99) == 0),
               ($urandom_range(0, 3) == 0),
               ($urandom_range(0, 5) == 0),
               $urandom,
               ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'd0,
               modes[$urandom_range(0, 2)],
               modes[$urandom_range(0, 2)],
               1'($urandom_range(0, 1)));
         @(negedge clk);
         if (i >= 2) compare("rand", i, model_out(), rst);
         @(posedge clk);
         model_step();
         #1;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
